// File: rtl/dcp_atmos_transmission_if.sv
// Pixel-side bundle of the dark-channel / transmittance stage: the incoming
// pixel stream plus the aligned pixel, transmittance and atmospheric-light outputs.
interface dcp_atmos_transmission_if;
   logic        i_vsync;
   logic [23:0] i_rgb;
   logic        i_data_valid;
   logic [23:0] o_rgb;
   logic [7:0]  o_transmittance;
   logic [7:0]  o_dark_max;
   logic        o_data_valid;
   logic        o_busy;

   modport master (
      output i_vsync, i_rgb, i_data_valid,
      input  o_rgb, o_transmittance, o_dark_max, o_data_valid, o_busy
   );

   modport slave (
      input  i_vsync, i_rgb, i_data_valid,
      output o_rgb, o_transmittance, o_dark_max, o_data_valid, o_busy
   );
endinterface

// File: rtl/dcp_atmos_transmission.sv
// Dark channel, per-frame atmospheric light A with a serial reciprocal divider,
// and a 4-stage per-pixel transmittance pipeline t = 255 - w*255*dark/A.
module dcp_atmos_transmission #(
   parameter int unsigned OMEGA  = 243,
   parameter int unsigned T_MIN  = 26,
   parameter int unsigned A_INIT = 255
) (
   input  logic                     pixelclk,
   input  logic                     reset,
   dcp_atmos_transmission_if.slave  px
);

   localparam logic [15:0] DIVIDEND   = 16'd65280;
   localparam logic [7:0]  OMEGA_C    = 8'(OMEGA);
   localparam logic [7:0]  T_MIN_C    = 8'(T_MIN);
   localparam logic [7:0]  A_INIT_C   = 8'(A_INIT);
   localparam logic [15:0] RECIP_INIT = 16'(65280 / A_INIT);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_UPDATE} state_t;

   function automatic logic [7:0] min3(input logic [23:0] rgb);
      logic [7:0] m;
      m = (rgb[23:16] < rgb[15:8]) ? rgb[23:16] : rgb[15:8];
      return (rgb[7:0] < m) ? rgb[7:0] : m;
   endfunction

   // (dark*recip)>>8 saturated to 255; covers dark above the previous frame's A.
   function automatic logic [7:0] sat_norm(input logic [23:0] prod);
      return (prod[23:16] != 8'd0) ? 8'hFF : prod[15:8];
   endfunction

   function automatic logic [7:0] clamp_t(input logic [7:0] haze);
      logic [7:0] t;
      t = 8'd255 - haze;
      return (t < T_MIN_C) ? T_MIN_C : t;
   endfunction

   state_t      state_q;
   logic        vsync_q;
   logic        vsync_edge;
   logic [7:0]  dark_c;
   logic [7:0]  frame_max_q;
   logic [7:0]  a_pend_q;
   logic [7:0]  a_cur_q;
   logic [15:0] recip_q;
   logic        busy_q;
   logic [3:0]  cnt_q;
   logic [8:0]  rem_q;
   logic [15:0] dvd_q;
   logic [15:0] quo_q;
   logic [8:0]  rem_sh;
   logic [8:0]  rem_d;
   logic [15:0] quo_d;
   logic        q_bit;

   assign vsync_edge = px.i_vsync & ~vsync_q;
   assign dark_c     = min3(px.i_rgb);

   // A pixel on the edge cycle seeds the new frame's maximum.
   always_ff @(posedge pixelclk) begin
      if (reset) begin
         vsync_q     <= 1'b0;
         frame_max_q <= 8'd0;
      end else begin
         vsync_q <= px.i_vsync;
         if (vsync_edge)
            frame_max_q <= px.i_data_valid ? dark_c : 8'd0;
         else if (px.i_data_valid && (dark_c > frame_max_q))
            frame_max_q <= dark_c;
      end
   end

   always_comb begin
      rem_sh = {rem_q[7:0], dvd_q[15]};
      q_bit  = (rem_sh >= {1'b0, a_pend_q});
      rem_d  = q_bit ? (rem_sh - {1'b0, a_pend_q}) : rem_sh;
      quo_d  = {quo_q[14:0], q_bit};
   end

   // A new edge always restarts the divider, so a_cur/recip only ever receive a finished pair.
   always_ff @(posedge pixelclk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         a_cur_q  <= A_INIT_C;
         recip_q  <= RECIP_INIT;
         a_pend_q <= 8'd1;
         cnt_q    <= 4'd0;
         rem_q    <= 9'd0;
         dvd_q    <= 16'd0;
         quo_q    <= 16'd0;
      end else if (vsync_edge) begin
         a_pend_q <= (frame_max_q == 8'd0) ? 8'd1 : frame_max_q;
         rem_q    <= 9'd0;
         dvd_q    <= DIVIDEND;
         quo_q    <= 16'd0;
         cnt_q    <= 4'd0;
         state_q  <= S_DIV;
         busy_q   <= 1'b1;
      end else begin
         case (state_q)
            S_DIV: begin
               rem_q <= rem_d;
               dvd_q <= {dvd_q[14:0], 1'b0};
               quo_q <= quo_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_q <= S_UPDATE;
            end
            S_UPDATE: begin
               a_cur_q <= a_pend_q;
               recip_q <= quo_q;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   logic        vld_p1, vld_p2, vld_p3, vld_p4;
   logic [23:0] rgb_p1, rgb_p2, rgb_p3, rgb_p4_q;
   logic [7:0]  dark_p1;
   logic [15:0] recip_p1;
   logic [7:0]  norm_p2;
   logic [7:0]  haze_p3;
   logic [7:0]  t_p4_q;
   logic [23:0] prod_c;
   logic [15:0] haze_prod_c;

   assign prod_c      = {16'd0, dark_p1} * {8'd0, recip_p1};
   assign haze_prod_c = {8'd0, norm_p2} * {8'd0, OMEGA_C};

   always_ff @(posedge pixelclk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
         vld_p4 <= 1'b0;
      end else begin
         vld_p1 <= px.i_data_valid;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
         vld_p4 <= vld_p3;
      end
   end

   // S1: dark channel; recip is captured here so a pixel sees one consistent A.
   always_ff @(posedge pixelclk) begin
      rgb_p1   <= px.i_rgb;
      dark_p1  <= dark_c;
      recip_p1 <= recip_q;
      // S2: normalised dark
      rgb_p2   <= rgb_p1;
      norm_p2  <= sat_norm(prod_c);
      // S3: haze = norm * omega
      rgb_p3   <= rgb_p2;
      haze_p3  <= haze_prod_c[15:8];
   end

   // S4: transmittance with floor
   always_ff @(posedge pixelclk) begin
      if (reset) begin
         rgb_p4_q <= 24'd0;
         t_p4_q   <= 8'd0;
      end else begin
         rgb_p4_q <= rgb_p3;
         t_p4_q   <= clamp_t(haze_p3);
      end
   end

   assign px.o_rgb           = rgb_p4_q;
   assign px.o_transmittance = t_p4_q;
   assign px.o_data_valid    = vld_p4;
   assign px.o_dark_max      = a_cur_q;
   assign px.o_busy          = busy_q;

endmodule

// File: tb/tb_dcp_atmos_transmission.sv
// Directed bench for dcp_atmos_transmission: reset state, pixel math,
// A update through the divider, black frame, restart on edge, reset abort.
module tb_dcp_atmos_transmission;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   dcp_atmos_transmission_if px();

   dcp_atmos_transmission #(.OMEGA(243), .T_MIN(26), .A_INIT(255)) dut (
      .pixelclk (clk),
      .reset    (rst),
      .px       (px)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      px.i_vsync = 1'b0;
      px.i_data_valid = 1'b0;
      px.i_rgb = 24'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [23:0] rgb);
      px.i_rgb = rgb;
      px.i_data_valid = 1'b1;
      tick();
      px.i_data_valid = 1'b0;
   endtask

   task automatic send_frame128();
      send({8'd200, 8'd128, 8'd250});
      send({8'd50,  8'd60,  8'd70});
      send({8'd128, 8'd255, 8'd129});
      send({8'd10,  8'd250, 8'd250});
   endtask

   initial begin
      px.i_vsync = 1'b0;
      px.i_data_valid = 1'b0;
      px.i_rgb = 24'd0;

      // reset defaults and basic pixel
      do_reset();
      chk("rst_valid", 32'(px.o_data_valid), 32'd0);
      chk("rst_busy", 32'(px.o_busy), 32'd0);
      chk("rst_dark_max", 32'(px.o_dark_max), 32'd255);
      chk("rst_rgb", 32'(px.o_rgb), 32'd0);
      chk("rst_t", 32'(px.o_transmittance), 32'd0);
      send({8'd100, 8'd150, 8'd200});
      tick();
      tick();
      chk("lat3_valid", 32'(px.o_data_valid), 32'd0);
      tick();
      chk("lat4_valid", 32'(px.o_data_valid), 32'd1);
      chk("pix_rgb", 32'(px.o_rgb), 32'h6496C8);
      chk("pix_t", 32'(px.o_transmittance), 32'd161);
      chk("pix_dark_max", 32'(px.o_dark_max), 32'd255);

      // clamp at T_MIN and zero-dark
      send({8'd255, 8'd255, 8'd255});
      send({8'd0, 8'd80, 8'd90});
      tick();
      tick();
      chk("white_t", 32'(px.o_transmittance), 32'd26);
      tick();
      chk("zero_t", 32'(px.o_transmittance), 32'd255);
      chk("zero_rgb", 32'(px.o_rgb), 32'h00505A);

      // A update to 128
      do_reset();
      send_frame128();
      px.i_vsync = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         chk($sformatf("upd_busy_%0d", k), 32'(px.o_busy), (k <= 17) ? 32'd1 : 32'd0);
         if (k == 17) chk("upd_dm_e17", 32'(px.o_dark_max), 32'd255);
         if (k == 18) chk("upd_dm_e18", 32'(px.o_dark_max), 32'd128);
      end
      px.i_vsync = 1'b0;
      tick();
      send({8'd64, 8'd100, 8'd200});
      tick();
      tick();
      tick();
      chk("upd_valid", 32'(px.o_data_valid), 32'd1);
      chk("upd_t", 32'(px.o_transmittance), 32'd135);

      // black frame -> A=1
      do_reset();
      send({8'd0, 8'd0, 8'd0});
      send({8'd0, 8'd255, 8'd255});
      px.i_vsync = 1'b1;
      for (int k = 1; k <= 18; k++) tick();
      chk("blk_dark_max", 32'(px.o_dark_max), 32'd1);
      px.i_vsync = 1'b0;
      send({8'd1, 8'd1, 8'd1});
      tick();
      tick();
      tick();
      chk("blk_t", 32'(px.o_transmittance), 32'd26);

      // second edge at E+5 restarts the divider; seed pixel dark 90 at E
      do_reset();
      send_frame128();
      for (int k = 1; k <= 24; k++) begin
         px.i_vsync = (k == 1) || (k >= 6);
         px.i_data_valid = (k == 1) || (k == 11);
         px.i_rgb = (k == 1) ? {8'd90, 8'd90, 8'd200} : {8'd100, 8'd150, 8'd200};
         tick();
         if (k == 14) begin
            chk("rst_div_mid_valid", 32'(px.o_data_valid), 32'd1);
            chk("rst_div_mid_t", 32'(px.o_transmittance), 32'd161);
         end
         if (k == 18) chk("rst_div_dm_e18", 32'(px.o_dark_max), 32'd255);
         if (k == 22) begin
            chk("rst_div_dm_e22", 32'(px.o_dark_max), 32'd255);
            chk("rst_div_busy_e22", 32'(px.o_busy), 32'd1);
         end
         if (k == 23) begin
            chk("rst_div_dm_e23", 32'(px.o_dark_max), 32'd90);
            chk("rst_div_busy_e23", 32'(px.o_busy), 32'd0);
         end
      end
      px.i_data_valid = 1'b0;
      px.i_vsync = 1'b0;
      tick();
      send({8'd45, 8'd200, 8'd200});
      tick();
      tick();
      tick();
      chk("rst_div_t90", 32'(px.o_transmittance), 32'd135);

      // reset at E+8 aborts the division and flushes in-flight valids
      do_reset();
      send_frame128();
      px.i_vsync = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         px.i_data_valid = (k >= 6);
         px.i_rgb = {8'd30, 8'd40, 8'd50};
         tick();
      end
      chk("abort_busy_pre", 32'(px.o_busy), 32'd1);
      rst = 1'b1;
      px.i_vsync = 1'b0;
      px.i_data_valid = 1'b1;
      tick();
      chk("abort_busy", 32'(px.o_busy), 32'd0);
      chk("abort_dark_max", 32'(px.o_dark_max), 32'd255);
      chk("abort_valid", 32'(px.o_data_valid), 32'd0);
      rst = 1'b0;
      px.i_data_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k <= 5) chk($sformatf("abort_novalid_%0d", k), 32'(px.o_data_valid), 32'd0);
      end
      chk("abort_dm_late", 32'(px.o_dark_max), 32'd255);
      chk("abort_busy_late", 32'(px.o_busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
